// File: rtl/tankwar_kbd_pkg.sv
// Purpose: scan-code constants, receiver state type and key-map lookup for the tank-war PS/2 front end.
// Latency: none (declarations and a combinational helper only).
// Backpressure: none; consumers act on single-cycle strobes.
package tankwar_kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int NUM_KEYS = 10;

  // Bit positions inside the packed key-level vector.
  localparam logic [3:0] KEY_UP1    = 4'd0;
  localparam logic [3:0] KEY_DOWN1  = 4'd1;
  localparam logic [3:0] KEY_LEFT1  = 4'd2;
  localparam logic [3:0] KEY_RIGHT1 = 4'd3;
  localparam logic [3:0] KEY_FIRE1  = 4'd4;
  localparam logic [3:0] KEY_UP2    = 4'd5;
  localparam logic [3:0] KEY_DOWN2  = 4'd6;
  localparam logic [3:0] KEY_LEFT2  = 4'd7;
  localparam logic [3:0] KEY_RIGHT2 = 4'd8;
  localparam logic [3:0] KEY_FIRE2  = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Map a scan code plus the pending extended flag onto a key slot.
  // Enter counts as fire2 whether it comes from the main block or the keypad.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KEY_UP1;
    if (code == SC_ENTER) begin
      r.idx = KEY_FIRE2;
    end else if (!ext) begin
      case (code)
        SC_W:     r.idx = KEY_UP1;
        SC_S:     r.idx = KEY_DOWN1;
        SC_A:     r.idx = KEY_LEFT1;
        SC_D:     r.idx = KEY_RIGHT1;
        SC_SPACE: r.idx = KEY_FIRE1;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = KEY_UP2;
        SC_DOWN:  r.idx = KEY_DOWN2;
        SC_LEFT:  r.idx = KEY_LEFT2;
        SC_RIGHT: r.idx = KEY_RIGHT2;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Purpose: PS/2 device-to-host frame receiver (sync, glitch filter, framing FSM, timeout, optional parity).
// Latency: raw ps2_clk fall -> fall strobe in 2+FILTER_LEN+1 cycles; scan_valid one cycle after the stop-bit fall.
// Backpressure: none; the PS/2 device cannot be stalled, byte_done/scan_valid are single-cycle strobes.
// Optional feature: define TANKWAR_PS2_PARITY_EN to reject frames with bad odd parity.
module ps2_frame_rx
  import tankwar_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       byte_done,
  output logic [7:0] byte_dat
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt;
  logic          fall;
  ps2_state_t    state_q;
  ps2_state_t    state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          par_ok;
  logic          err_d;

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign byte_dat = shift_q;

  // Two-flop synchronizers; reset to the idle-high line level so no edge is seen at reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Clock filter: the level flips only after FILTER_LEN consecutive differing samples; fall strobes on 1->0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_cnt <= '0;
      clk_flt <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        clk_flt <= clk_s;
        fall    <= clk_flt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

`ifdef TANKWAR_PS2_PARITY_EN
  logic par_q;

  // Capture the parity bit; a good frame has an odd number of ones over data plus parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (fall && state_q == PARITY) begin
      par_q <= dat_s;
    end
  end

  assign par_ok = ^{shift_q, par_q};
`else
  // The parity bit is clocked through the PARITY state but not checked.
  assign par_ok = 1'b1;
`endif

  // A stalled frame is abandoned once the gap since the last fall reaches the limit.
  assign timeout = (state_q != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));

  // Next state and completion/error strobes.
  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) state_d = DATA;
          else        err_d   = 1'b1;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (dat_s && par_ok) byte_done = 1'b1;
          else                 err_d     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register, data shifter and bit counter (LSB arrives first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (fall && state_q == IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state_q == DATA) begin
        shift_q <= {dat_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Saturating gap counter, held at zero while idle and cleared by every fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (fall || state_q == IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Registered byte output and status strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= byte_done;
      frame_err  <= err_d;
      if (byte_done) scan_code <= shift_q;
    end
  end

endmodule

// File: rtl/tankwar_ps2_keys.sv
// Purpose: PS/2 keyboard front end producing held key levels for both tank-war players.
// Latency: key level, scan_code and scan_valid all update one cycle after the stop-bit filtered fall.
// Backpressure: none; every decoded byte is consumed in the cycle it completes.
// Optional feature: define TANKWAR_PS2_PARITY_EN to enforce odd parity on received frames.
module tankwar_ps2_keys
  import tankwar_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up1,
  output logic       down1,
  output logic       left1,
  output logic       right1,
  output logic       fire1,
  output logic       up2,
  output logic       down2,
  output logic       left2,
  output logic       right2,
  output logic       fire2,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic                byte_done;
  logic [7:0]          byte_dat;
  logic                ext_q;
  logic                brk_q;
  logic [NUM_KEYS-1:0] keys_q;
  key_hit_t            hit;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err),
    .byte_done  (byte_done),
    .byte_dat   (byte_dat)
  );

  assign hit = key_lookup(byte_dat, ext_q);

  // Prefix flags accumulate in any order; the next non-prefix byte applies them and clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else if (byte_done) begin
      if (byte_dat == SC_E0) begin
        ext_q <= 1'b1;
      end else if (byte_dat == SC_F0) begin
        brk_q <= 1'b1;
      end else begin
        if (hit.hit) keys_q[hit.idx] <= ~brk_q;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign up1    = keys_q[KEY_UP1];
  assign down1  = keys_q[KEY_DOWN1];
  assign left1  = keys_q[KEY_LEFT1];
  assign right1 = keys_q[KEY_RIGHT1];
  assign fire1  = keys_q[KEY_FIRE1];
  assign up2    = keys_q[KEY_UP2];
  assign down2  = keys_q[KEY_DOWN2];
  assign left2  = keys_q[KEY_LEFT2];
  assign right2 = keys_q[KEY_RIGHT2];
  assign fire2  = keys_q[KEY_FIRE2];

endmodule
